mux_scan_nx: RTL and testbench
==============================

Name: mux_scan_nx

Overview:
Parametrised time-multiplexing selector, the next generation of the team's fixed 2:1 byte mux. It rotates through CHANNELS input words of WIDTH bits, dwelling SCAN_DIV clocks on each, and presents the selected word on a registered output with an aligned one-hot select. It sits between the counter/BCD datapath and the multiplexed seven-segment display driver. It also supports channel masking, a manual force-select mode and a scan pause.

Parameters:
WIDTH, 8, bits per channel word
CHANNELS, 4, number of input channels (>= 2)
SCAN_DIV, 16, clocks spent on each channel (>= 1; 1 = advance every clock)
SEL_W, $clog2(CHANNELS), select index width (derived, not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_bus  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
chan_mask  in  CHANNELS  1 = channel takes part in the scan
scan_en  in  1  1 = prescaler runs; 0 = pause on the current channel
force_en  in  1  1 = override scan, select force_sel
force_sel  in  SEL_W  forced channel index
o  out  WIDTH  registered selected word
sel_onehot  out  CHANNELS  registered one-hot of the channel shown on o, all-zero when blanked
sel_idx  out  SEL_W  current select index (state register)
o_valid  out  1  1 = o holds live channel data
scan_wrap  out  1  one-clock pulse when the scan returns to a lower-or-equal index

Behaviour:
- Reset (async assert, sync-released use): prescaler=0, sel_idx=0, o=0, sel_onehot=0, o_valid=0, scan_wrap=0.
- Output path: every clock, o <= in_bus word[sel_idx]; sel_onehot <= 1<<sel_idx; o_valid <= 1.
  - The three outputs update together with 1-clock latency from sel_idx/in_bus.
  - in_bus changes propagate to o even while paused.
- Blanking: if force_en=0 and (chan_mask==0 or chan_mask[sel_idx]==0), then o<=0, sel_onehot<=0, o_valid<=0.
- Prescaler: counts 0..SCAN_DIV-1 while scan_en=1 and force_en=0. It holds when scan_en=0.
- Advance: at prescaler==SCAN_DIV-1 with scan_en=1 and force_en=0:
  - prescaler<=0.
  - sel_idx <= first index with mask bit set, searching circularly from sel_idx+1. The search covers sel_idx itself last.
  - scan_wrap<=1 for one clock if the new index <= the old index, including when only one channel is enabled.
  - If chan_mask==0: sel_idx holds and scan_wrap stays 0.
- A channel masked off mid-dwell blanks immediately; the scan advances at the next terminal count.
- Force: while force_en=1, prescaler<=0 and scan_wrap=0.
  - sel_idx <= force_sel if force_sel < CHANNELS; otherwise sel_idx holds.
  - Mask is ignored, so the forced channel is always shown with o_valid=1.
  - On release, scanning resumes from the forced index with a full SCAN_DIV dwell.
- Precedence: reset > force_en > scan_en/advance > hold.
- Non-power-of-2 CHANNELS: indices >= CHANNELS are never reached by scanning.

Decomposition:
- Shared package: clog2-based width helper and the default WIDTH/CHANNELS/SCAN_DIV constants used by the display path.
- One combinational sub-module, mux_next_chan (CHANNELS, SEL_W). Inputs: mask, current index. Outputs: next enabled index, wrap flag, none-enabled flag.
- Prescaler, select register and output register live in the top.

Test Plan:
1. WIDTH=8, CHANNELS=4, SCAN_DIV=4; words 0x11,0x22,0x33,0x44; mask=4'b1111; scan_en=1 -> o shows 0x11, 0x22, 0x33, 0x44, 0x11 for 4 clocks each, each one clock after sel_idx changes. sel_onehot is 0001, 0010, 0100, 1000. scan_wrap pulses once on the 3->0 step.
2. mask=4'b1010 from reset -> o=0 and o_valid=0 for the first dwell. Then the scan alternates 0x22/0x44 every 4 clocks, and scan_wrap pulses on the 3->1 step.
3. Mid-dwell on ch2: force_en=1, force_sel=3 for 10 clocks -> o=0x44 and o_valid=1 from the next clock, with no advance. On release, ch3 dwells 4 clocks, then ch0 is shown.
4. scan_en=0 for 7 clocks during ch1, changing word1 to 0x5A -> sel_idx stays 1, o becomes 0x5A after 1 clock. After re-enable, the remaining dwell completes exactly.
5. mask=0 -> o=0, o_valid=0, sel_onehot=0 and no scan_wrap. Setting mask=4'b0100 -> ch2 is selected at the next terminal count, and scan_wrap pulses every 4 clocks after that.
6. Assert rst_n=0 asynchronously mid-dwell, between clock edges -> all outputs are 0 immediately. After release, the scan restarts at ch0 with the prescaler at 0. Also: force_sel=5 with CHANNELS=5 holds sel_idx.

Source files
------------

// File: rtl/mux_scan_nx_pkg.sv
// Shared constants and width helper for the scanned display multiplexer.
// The defaults are the ones the seven-segment display path uses.
package mux_scan_nx_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_SCAN_DIV = 16;

    // Index width that never collapses to zero bits, even for n == 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_next_chan.sv
// Circular search for the next enabled channel after the current index.
// The current index itself is tried last, so a single enabled channel selects itself.
module mux_next_chan #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] mask,
    input  logic [SEL_W-1:0]    cur,
    output logic [SEL_W-1:0]    nxt,
    output logic                wrap,
    output logic                none
);

    int   cand;
    logic found;

    always_comb begin
        nxt   = cur;
        found = 1'b0;
        cand  = 0;
        for (int off = 1; off <= CHANNELS; off++) begin
            cand = int'(cur) + off;
            // Two folds cover any cur below 2**SEL_W, which is under 2*CHANNELS.
            if (cand >= CHANNELS) cand = cand - CHANNELS;
            if (cand >= CHANNELS) cand = cand - CHANNELS;
            if (!found && mask[cand]) begin
                nxt   = SEL_W'(cand);
                found = 1'b1;
            end
        end
        none = (mask == '0);
        wrap = found && (nxt <= cur);
    end

endmodule

// File: rtl/mux_scan_nx.sv
// Time-multiplexing word selector: rotates through the enabled channels with a
// fixed dwell and presents the chosen word on a registered, blankable output.
module mux_scan_nx
    import mux_scan_nx_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int SEL_W    = idx_width(CHANNELS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CHANNELS*WIDTH-1:0]   in_bus,
    input  logic [CHANNELS-1:0]         chan_mask,
    input  logic                        scan_en,
    input  logic                        force_en,
    input  logic [SEL_W-1:0]            force_sel,
    output logic [WIDTH-1:0]            o,
    output logic [CHANNELS-1:0]         sel_onehot,
    output logic [SEL_W-1:0]            sel_idx,
    output logic                        o_valid,
    output logic                        scan_wrap
);

    localparam int PW = idx_width(SCAN_DIV);
    localparam logic [PW-1:0]    PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CHANNELS);

    logic [PW-1:0]      prescale_reg;
    logic [WIDTH-1:0]   words [CHANNELS];
    logic [SEL_W-1:0]   next_idx;
    logic               next_wrap;
    logic               none_enabled;
    logic               blank;
    logic               force_ok;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_words
            assign words[gi] = in_bus[gi*WIDTH +: WIDTH];
        end
    endgenerate

    mux_next_chan #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_next (
        .mask (chan_mask),
        .cur  (sel_idx),
        .nxt  (next_idx),
        .wrap (next_wrap),
        .none (none_enabled)
    );

    assign force_ok = ({1'b0, force_sel} < CH_LIM);
    assign blank    = !force_en && (none_enabled || !chan_mask[sel_idx]);

    // Prescaler and select index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_reg <= '0;
            sel_idx      <= '0;
            scan_wrap    <= 1'b0;
        end else if (force_en) begin
            prescale_reg <= '0;
            scan_wrap    <= 1'b0;
            if (force_ok) sel_idx <= force_sel;
        end else if (scan_en) begin
            if (prescale_reg == PRE_LAST) begin
                prescale_reg <= '0;
                if (!none_enabled) begin
                    sel_idx   <= next_idx;
                    scan_wrap <= next_wrap;
                end else begin
                    scan_wrap <= 1'b0;
                end
            end else begin
                prescale_reg <= prescale_reg + 1'b1;
                scan_wrap    <= 1'b0;
            end
        end else begin
            scan_wrap <= 1'b0;
        end
    end

    // Output register follows sel_idx and in_bus one clock later, paused or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o          <= '0;
            sel_onehot <= '0;
            o_valid    <= 1'b0;
        end else if (blank) begin
            o          <= '0;
            sel_onehot <= '0;
            o_valid    <= 1'b0;
        end else begin
            o          <= words[sel_idx];
            sel_onehot <= CHANNELS'(1) << sel_idx;
            o_valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_scan_nx.sv
// Directed bench for mux_scan_nx: a 4-channel instance with SCAN_DIV=4 and a
// 5-channel instance for out-of-range force indices.
module tb_mux_scan_nx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] in_bus;
    logic [3:0]  chan_mask;
    logic        scan_en, force_en;
    logic [1:0]  force_sel;
    logic [7:0]  o;
    logic [3:0]  sel_onehot;
    logic [1:0]  sel_idx;
    logic        o_valid, scan_wrap;

    logic [39:0] in_bus5;
    logic [4:0]  chan_mask5;
    logic        scan_en5, force_en5;
    logic [2:0]  force_sel5;
    logic [7:0]  o5;
    logic [4:0]  sel_onehot5;
    logic [2:0]  sel_idx5;
    logic        o_valid5, scan_wrap5;

    int checks = 0;
    int errors = 0;

    logic [7:0] wv [4];

    always #5 clk = ~clk;

    mux_scan_nx #(.WIDTH(8), .CHANNELS(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .chan_mask(chan_mask),
        .scan_en(scan_en), .force_en(force_en), .force_sel(force_sel),
        .o(o), .sel_onehot(sel_onehot), .sel_idx(sel_idx),
        .o_valid(o_valid), .scan_wrap(scan_wrap)
    );

    mux_scan_nx #(.WIDTH(8), .CHANNELS(5), .SCAN_DIV(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus5), .chan_mask(chan_mask5),
        .scan_en(scan_en5), .force_en(force_en5), .force_sel(force_sel5),
        .o(o5), .sel_onehot(sel_onehot5), .sel_idx(sel_idx5),
        .o_valid(o_valid5), .scan_wrap(scan_wrap5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held over one clock edge; release lands at a negedge, so tick 1 is
    // the first active edge out of reset.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_o", {24'h0, o}, 32'h0);
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        wv[0] = 8'h11; wv[1] = 8'h22; wv[2] = 8'h33; wv[3] = 8'h44;
        in_bus    = 32'h44332211;
        chan_mask = 4'b1111;
        scan_en   = 1'b1;
        force_en  = 1'b0;
        force_sel = 2'd0;
        in_bus5    = 40'h5544332211;
        chan_mask5 = 5'b11111;
        scan_en5   = 1'b0;
        force_en5  = 1'b0;
        force_sel5 = 3'd0;

        // 1: full rotation, 4 clocks per channel, wrap on 3->0
        do_reset();
        check("t1_rst_sel", {30'h0, sel_idx}, 32'h0);
        check("t1_rst_onehot", {28'h0, sel_onehot}, 32'h0);
        check("t1_rst_wrap", {31'h0, scan_wrap}, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("t1_o_%0d", i), {24'h0, o}, {24'h0, wv[((i - 1) / 4) % 4]});
            check($sformatf("t1_oh_%0d", i), {28'h0, sel_onehot}, 32'(1 << (((i - 1) / 4) % 4)));
            check($sformatf("t1_sel_%0d", i), {30'h0, sel_idx}, 32'((i / 4) % 4));
            check($sformatf("t1_wrap_%0d", i), {31'h0, scan_wrap}, (i == 16) ? 32'h1 : 32'h0);
            check($sformatf("t1_valid_%0d", i), {31'h0, o_valid}, 32'h1);
        end

        // 2: mask 1010 -> blank first dwell, then 0x22/0x44, wrap on 3->1
        chan_mask = 4'b1010;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i <= 4) begin
                check($sformatf("t2_o_%0d", i), {24'h0, o}, 32'h0);
                check($sformatf("t2_valid_%0d", i), {31'h0, o_valid}, 32'h0);
                check($sformatf("t2_oh_%0d", i), {28'h0, sel_onehot}, 32'h0);
            end else begin
                check($sformatf("t2_o_%0d", i), {24'h0, o},
                      (i <= 8 || i >= 13) ? 32'h22 : 32'h44);
                check($sformatf("t2_valid_%0d", i), {31'h0, o_valid}, 32'h1);
            end
            check($sformatf("t2_wrap_%0d", i), {31'h0, scan_wrap}, (i == 12) ? 32'h1 : 32'h0);
        end

        // 3: force ch3 mid-dwell on ch2 for 10 clocks, then full dwell on ch3
        chan_mask = 4'b1111;
        do_reset();
        for (int i = 1; i <= 10; i++) tick();
        check("t3_pre_o", {24'h0, o}, 32'h33);
        force_en = 1'b1; force_sel = 2'd3;
        for (int i = 11; i <= 20; i++) begin
            tick();
            check($sformatf("t3_sel_%0d", i), {30'h0, sel_idx}, 32'h3);
            check($sformatf("t3_wrap_%0d", i), {31'h0, scan_wrap}, 32'h0);
            if (i >= 12) check($sformatf("t3_o_%0d", i), {24'h0, o}, 32'h44);
            if (i >= 12) check($sformatf("t3_valid_%0d", i), {31'h0, o_valid}, 32'h1);
        end
        force_en = 1'b0;
        for (int i = 21; i <= 25; i++) begin
            tick();
            check($sformatf("t3_rel_o_%0d", i), {24'h0, o}, (i <= 24) ? 32'h44 : 32'h11);
            check($sformatf("t3_rel_wrap_%0d", i), {31'h0, scan_wrap}, (i == 24) ? 32'h1 : 32'h0);
        end

        // 4: pause 7 clocks during ch1 and change word1 to 0x5A
        do_reset();
        for (int i = 1; i <= 5; i++) tick();
        scan_en = 1'b0;
        in_bus[15:8] = 8'h5A;
        for (int i = 6; i <= 12; i++) begin
            tick();
            check($sformatf("t4_sel_%0d", i), {30'h0, sel_idx}, 32'h1);
            check($sformatf("t4_o_%0d", i), {24'h0, o}, 32'h5A);
        end
        scan_en = 1'b1;
        tick(); check("t4_sel_13", {30'h0, sel_idx}, 32'h1);
        tick(); check("t4_sel_14", {30'h0, sel_idx}, 32'h1);
        tick(); check("t4_sel_15", {30'h0, sel_idx}, 32'h2);
        check("t4_o_15", {24'h0, o}, 32'h5A);
        tick(); check("t4_o_16", {24'h0, o}, 32'h33);
        in_bus[15:8] = 8'h22;

        // 5: mask 0 -> blank, no wrap; then only ch2 -> wraps every 4 clocks
        chan_mask = 4'b0000;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("t5_o_%0d", i), {24'h0, o}, 32'h0);
            check($sformatf("t5_valid_%0d", i), {31'h0, o_valid}, 32'h0);
            check($sformatf("t5_oh_%0d", i), {28'h0, sel_onehot}, 32'h0);
            check($sformatf("t5_wrap_%0d", i), {31'h0, scan_wrap}, 32'h0);
            check($sformatf("t5_sel_%0d", i), {30'h0, sel_idx}, 32'h0);
        end
        chan_mask = 4'b0100;
        for (int i = 9; i <= 20; i++) begin
            tick();
            check($sformatf("t5b_wrap_%0d", i), {31'h0, scan_wrap},
                  (i == 16 || i == 20) ? 32'h1 : 32'h0);
            if (i == 12) check("t5b_sel_12", {30'h0, sel_idx}, 32'h2);
            if (i <= 12) check($sformatf("t5b_valid_%0d", i), {31'h0, o_valid}, 32'h0);
            if (i >= 13) check($sformatf("t5b_o_%0d", i), {24'h0, o}, 32'h33);
            if (i >= 13) check($sformatf("t5b_oh_%0d", i), {28'h0, sel_onehot}, 32'h4);
        end

        // 6: asynchronous reset between edges, then restart from ch0
        chan_mask = 4'b1111;
        do_reset();
        for (int i = 1; i <= 6; i++) tick();
        check("t6_pre_o", {24'h0, o}, 32'h22);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_o", {24'h0, o}, 32'h0);
        check("t6_async_valid", {31'h0, o_valid}, 32'h0);
        check("t6_async_oh", {28'h0, sel_onehot}, 32'h0);
        check("t6_async_sel", {30'h0, sel_idx}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("t6_o_%0d", i), {24'h0, o}, (i <= 4) ? 32'h11 : 32'h22);
        end

        // 6b: five channels, out-of-range force index holds sel_idx
        force_en5 = 1'b1; force_sel5 = 3'd2;
        tick(); check("t6b_sel_f2", {29'h0, sel_idx5}, 32'h2);
        force_sel5 = 3'd5;
        tick(); check("t6b_sel_f5", {29'h0, sel_idx5}, 32'h2);
        check("t6b_o_f5", {24'h0, o5}, 32'h33);
        force_sel5 = 3'd7;
        tick(); check("t6b_sel_f7", {29'h0, sel_idx5}, 32'h2);
        check("t6b_valid_f7", {31'h0, o_valid5}, 32'h1);
        force_en5 = 1'b0; scan_en5 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("t6b_sel_%0d", i), {29'h0, sel_idx5},
                  (i < 4) ? 32'h2 : (i < 8) ? 32'h3 : (i < 12) ? 32'h4 : 32'h0);
            check($sformatf("t6b_wrap_%0d", i), {31'h0, scan_wrap5}, (i == 12) ? 32'h1 : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
